// File: rtl/pipelined_instruction_decoder.sv
// RV32I/RV64I decode stage: combinational decode of the fetched word, written
// into a small FIFO of control bundles so fetch and execute stall independently.
module pipelined_instruction_decoder #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_ir,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [TAG_W-1:0]         out_tag,
  output logic [4:0]               out_alu_op,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic [1:0]               out_wb_type,
  output logic [1:0]               out_rd_status,
  output logic [1:0]               out_wr_status,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic                     out_use_rs1,
  output logic                     out_use_rs2,
  output logic                     out_load_signed,
  output logic                     out_pc_a,
  output logic                     out_branch,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [4:0] IADD = 5'd0,  ISUB = 5'd1,  ISLL = 5'd2,  ISLT = 5'd3,
                         ISLTU = 5'd4, IXOR = 5'd5,  ISRL = 5'd6,  ISRA = 5'd7,
                         IOR = 5'd8,   IAND = 5'd9,  IPAS = 5'd10, IEQ = 5'd11,
                         INE = 5'd12,  ILT = 5'd13,  IGE = 5'd14,  ILTU = 5'd15,
                         IGEU = 5'd16;
  localparam logic [2:0] FT_R = 3'd0, FT_I = 3'd1, FT_S = 3'd2, FT_B = 3'd3,
                         FT_U = 3'd4, FT_J = 3'd5, FT_NONE = 3'd6;
  localparam logic [1:0] WB_NORMAL = 2'd0, WB_LOAD = 2'd1, WB_JAL = 2'd2;
  localparam logic [1:0] DM_NONE = 2'd0, DM_BYTE = 2'd1, DM_HWORD = 2'd2, DM_WORD = 2'd3;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_BR = 7'b1100011,  OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP = 7'b0110011,  OPC_FENCE = 7'b0001111,
                         OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
    logic [4:0]       alu_op;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [1:0]       wb_type;
    logic [1:0]       rd_status;
    logic [1:0]       wr_status;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic             load_signed;
    logic             pc_a;
    logic             branch;
    logic             illegal;
  } bundle_t;

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [6:0]       sh_f7;
  logic             ill;
  logic [31:0]      imm32;
  bundle_t          dec;

  bundle_t          mem [DEPTH];
  bundle_t          last_q;
  bundle_t          head_b;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;
  logic             push, pop;

  assign opcode = in_ir[6:0];
  assign f3     = in_ir[14:12];
  assign f7     = in_ir[31:25];

  // RV64 shift amounts are six bits wide, so IR[25] belongs to shamt there
  always_comb begin
    sh_f7 = f7;
    if (XLEN == 64) sh_f7[0] = 1'b0;
  end

  // Decode of the word at the FIFO input
  always_comb begin
    dec         = '0;
    ill         = 1'b0;
    imm32       = '0;
    dec.pc      = in_pc;
    dec.tag     = tag_q;
    dec.alu_op  = IADD;
    dec.fmt     = FT_NONE;
    dec.rd      = in_ir[11:7];
    dec.rs1     = in_ir[19:15];
    dec.rs2     = in_ir[24:20];
    case (opcode)
      OPC_LUI: begin
        dec.fmt    = FT_U;
        dec.alu_op = IPAS;
      end
      OPC_AUIPC: begin
        dec.fmt  = FT_U;
        dec.pc_a = 1'b1;
      end
      OPC_JAL: begin
        dec.fmt     = FT_J;
        dec.pc_a    = 1'b1;
        dec.branch  = 1'b1;
        dec.wb_type = WB_JAL;
      end
      OPC_JALR: begin
        dec.fmt     = FT_I;
        dec.branch  = 1'b1;
        dec.wb_type = WB_JAL;
      end
      OPC_BR: begin
        dec.fmt    = FT_B;
        dec.branch = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = IEQ;
          3'b001:  dec.alu_op = INE;
          3'b100:  dec.alu_op = ILT;
          3'b101:  dec.alu_op = IGE;
          3'b110:  dec.alu_op = ILTU;
          3'b111:  dec.alu_op = IGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.fmt         = FT_I;
        dec.wb_type     = WB_LOAD;
        dec.load_signed = ~f3[2];
        case (f3)
          3'b000, 3'b100: dec.rd_status = DM_BYTE;
          3'b001, 3'b101: dec.rd_status = DM_HWORD;
          3'b010, 3'b110: dec.rd_status = DM_WORD;
          default:        ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.fmt = FT_S;
        case (f3)
          3'b000:  dec.wr_status = DM_BYTE;
          3'b001:  dec.wr_status = DM_HWORD;
          3'b010:  dec.wr_status = DM_WORD;
          default: ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.fmt = FT_I;
        case (f3)
          3'b000: dec.alu_op = IADD;
          3'b010: dec.alu_op = ISLT;
          3'b011: dec.alu_op = ISLTU;
          3'b100: dec.alu_op = IXOR;
          3'b110: dec.alu_op = IOR;
          3'b111: dec.alu_op = IAND;
          3'b001: begin
            if (sh_f7 == 7'b0000000) dec.alu_op = ISLL;
            else                     ill = 1'b1;
          end
          default: begin
            if (sh_f7 == 7'b0000000)      dec.alu_op = ISRL;
            else if (sh_f7 == 7'b0100000) dec.alu_op = ISRA;
            else                          ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.fmt = FT_R;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.alu_op = IADD;
            3'b001:  dec.alu_op = ISLL;
            3'b010:  dec.alu_op = ISLT;
            3'b011:  dec.alu_op = ISLTU;
            3'b100:  dec.alu_op = IXOR;
            3'b101:  dec.alu_op = ISRL;
            3'b110:  dec.alu_op = IOR;
            default: dec.alu_op = IAND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu_op = ISUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.alu_op = ISRA;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_FENCE, OPC_SYSTEM: dec.fmt = FT_NONE;
      default: ill = 1'b1;
    endcase

    // Undecodable words collapse to a harmless bundle flagged illegal
    if (ill) begin
      dec.fmt         = FT_NONE;
      dec.alu_op      = IADD;
      dec.wb_type     = WB_NORMAL;
      dec.rd_status   = DM_NONE;
      dec.wr_status   = DM_NONE;
      dec.load_signed = 1'b0;
      dec.pc_a        = 1'b0;
      dec.branch      = 1'b0;
      dec.illegal     = 1'b1;
    end

    if (dec.fmt == FT_S || dec.fmt == FT_B || dec.fmt == FT_NONE) dec.rd = 5'd0;
    dec.use_rs1 = (dec.fmt == FT_R) || (dec.fmt == FT_I) || (dec.fmt == FT_S) || (dec.fmt == FT_B);
    dec.use_rs2 = (dec.fmt == FT_R) || (dec.fmt == FT_S) || (dec.fmt == FT_B);

    case (dec.fmt)
      FT_I:    imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
      FT_S:    imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
      FT_B:    imm32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
      FT_U:    imm32 = {in_ir[31:12], 12'h000};
      FT_J:    imm32 = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
      default: imm32 = 32'h0;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  assign in_ready  = (cnt_q < CNT_W'(DEPTH)) && !flush;
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = cnt_q;

  // Bundle storage carries no reset; validity lives in cnt_q
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      last_q     <= '0;
      last_q.fmt <= FT_NONE;
    end else begin
      if (push) tag_q <= tag_q + TAG_W'(1);
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) tail_q <= tail_q + PTR_W'(1);
        if (pop) begin
          head_q <= head_q + PTR_W'(1);
          last_q <= mem[head_q];
        end
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // An empty FIFO keeps presenting the most recently consumed bundle
  assign head_b = out_valid ? mem[head_q] : last_q;

  assign out_pc          = head_b.pc;
  assign out_tag         = head_b.tag;
  assign out_alu_op      = head_b.alu_op;
  assign out_imm         = head_b.imm;
  assign out_fmt         = head_b.fmt;
  assign out_wb_type     = head_b.wb_type;
  assign out_rd_status   = head_b.rd_status;
  assign out_wr_status   = head_b.wr_status;
  assign out_rd          = head_b.rd;
  assign out_rs1         = head_b.rs1;
  assign out_rs2         = head_b.rs2;
  assign out_use_rs1     = head_b.use_rs1;
  assign out_use_rs2     = head_b.use_rs2;
  assign out_load_signed = head_b.load_signed;
  assign out_pc_a        = head_b.pc_a;
  assign out_branch      = head_b.branch;
  assign out_illegal     = head_b.illegal;

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Table of hand-decoded instruction words fed through the decoder, with a
// queue of expected bundles checked as execute consumes each head entry.
module tb_pipelined_instruction_decoder;

  localparam int unsigned XLEN = 32, DEPTH = 2, TAG_W = 4, NV = 19;

  localparam logic [4:0] IADD = 5'd0, ISUB = 5'd1, ISRA = 5'd7, IPAS = 5'd10,
                         IEQ = 5'd11, IGEU = 5'd16;
  localparam logic [2:0] FT_R = 3'd0, FT_I = 3'd1, FT_S = 3'd2, FT_B = 3'd3,
                         FT_U = 3'd4, FT_J = 3'd5, FT_NONE = 3'd6;
  localparam logic [1:0] WBN = 2'd0, WBL = 2'd1, WBJ = 2'd2;
  localparam logic [1:0] DN = 2'd0, DB = 2'd1, DH = 2'd2, DW = 2'd3;

  typedef struct packed {
    logic [31:0] ir;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [1:0]  wb, rds, wrs;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, ls, pca, br, ill;
  } vec_t;

  typedef struct packed {
    vec_t             v;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
  } sb_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_ir, in_pc, out_pc, out_imm;
  logic [TAG_W-1:0] out_tag;
  logic [4:0] out_alu_op, out_rd, out_rs1, out_rs2;
  logic [2:0] out_fmt;
  logic [1:0] out_wb_type, out_rd_status, out_wr_status;
  logic out_use_rs1, out_use_rs2, out_load_signed, out_pc_a, out_branch, out_illegal;
  logic [$clog2(DEPTH):0] count;

  pipelined_instruction_decoder #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_tag(out_tag),
    .out_alu_op(out_alu_op), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_wb_type(out_wb_type), .out_rd_status(out_rd_status), .out_wr_status(out_wr_status),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
    .out_load_signed(out_load_signed), .out_pc_a(out_pc_a), .out_branch(out_branch),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;
  vec_t tbl [NV];
  vec_t cur;
  sb_t  sb [$];
  logic [TAG_W-1:0] tag_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ir, input logic [4:0] alu, input logic [31:0] imm,
                              input logic [2:0] fmt, input logic [1:0] wb, input logic [1:0] rds,
                              input logic [1:0] wrs, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2, input logic ls,
                              input logic pca, input logic br, input logic ill);
    vec_t v;
    v = '{ir, alu, imm, fmt, wb, rds, wrs, rd, rs1, rs2, u1, u2, ls, pca, br, ill};
    return v;
  endfunction

  task automatic cmp_head(input sb_t e);
    string p;
    p = $sformatf("%08h", e.v.ir);
    chk({p, ".tag"}, 64'(out_tag), 64'(e.tag));
    chk({p, ".pc"}, 64'(out_pc), 64'(e.pc));
    chk({p, ".alu"}, 64'(out_alu_op), 64'(e.v.alu));
    chk({p, ".imm"}, 64'(out_imm), 64'(e.v.imm));
    chk({p, ".fmt"}, 64'(out_fmt), 64'(e.v.fmt));
    chk({p, ".wb"}, 64'(out_wb_type), 64'(e.v.wb));
    chk({p, ".rd_status"}, 64'(out_rd_status), 64'(e.v.rds));
    chk({p, ".wr_status"}, 64'(out_wr_status), 64'(e.v.wrs));
    chk({p, ".rd"}, 64'(out_rd), 64'(e.v.rd));
    chk({p, ".rs1"}, 64'(out_rs1), 64'(e.v.rs1));
    chk({p, ".rs2"}, 64'(out_rs2), 64'(e.v.rs2));
    chk({p, ".flags"}, 64'({out_use_rs1, out_use_rs2, out_load_signed, out_pc_a, out_branch, out_illegal}),
        64'({e.v.u1, e.v.u2, e.v.ls, e.v.pca, e.v.br, e.v.ill}));
  endtask

  // Scoreboard: sampled mid-cycle, so each handshake seen here completes at the next edge
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      tag_m = '0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("pop_with_empty_scoreboard", 64'(out_valid), 64'd0);
        else cmp_head(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        sb.push_back('{cur, in_pc, tag_m});
        tag_m = tag_m + TAG_W'(1);
      end
    end
  end

  task automatic send(input int idx);
    logic acc;
    cur      = tbl[idx];
    in_ir    = tbl[idx].ir;
    in_pc    = 32'h1000 + 32'(idx) * 32'd4;
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    n_total++;
    n_bad++;
    $display("FAIL accept_timeout: word %08h never accepted", tbl[idx].ir);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (!out_valid && sb.size() == 0) return;
      @(posedge clk);
      #1;
    end
    n_total++;
    n_bad++;
    $display("FAIL drain_timeout: out_valid=%0d pending=%0d", out_valid, sb.size());
  endtask

  initial begin
    int t0;
    tbl[0]  = mk(32'h00500093, IADD, 32'h5,        FT_I,    WBN, DN, DN, 1, 0, 5,  1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h12345137, IPAS, 32'h12345000, FT_U,    WBN, DN, DN, 2, 8, 3,  0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(32'h00112423, IADD, 32'h8,        FT_S,    WBN, DN, DW, 0, 2, 1,  1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(32'hFE000EE3, IEQ,  32'hFFFFFFFC, FT_B,    WBN, DN, DN, 0, 0, 0,  1, 1, 0, 0, 1, 0);
    tbl[4]  = mk(32'h0000707F, IADD, 32'h0,        FT_NONE, WBN, DN, DN, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(32'h40001013, IADD, 32'h0,        FT_NONE, WBN, DN, DN, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(32'h402081B3, ISUB, 32'h0,        FT_R,    WBN, DN, DN, 3, 1, 2,  1, 1, 0, 0, 0, 0);
    tbl[7]  = mk(32'hFFE35283, IADD, 32'hFFFFFFFE, FT_I,    WBL, DH, DN, 5, 6, 30, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(32'h00008383, IADD, 32'h0,        FT_I,    WBL, DB, DN, 7, 1, 0,  1, 0, 1, 0, 0, 0);
    tbl[9]  = mk(32'h010000EF, IADD, 32'h10,       FT_J,    WBJ, DN, DN, 1, 0, 16, 0, 0, 0, 1, 1, 0);
    tbl[10] = mk(32'h80000217, IADD, 32'h80000000, FT_U,    WBN, DN, DN, 4, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[11] = mk(32'h00008067, IADD, 32'h0,        FT_I,    WBJ, DN, DN, 0, 1, 0,  1, 0, 0, 0, 1, 0);
    tbl[12] = mk(32'h4041D113, ISRA, 32'h404,      FT_I,    WBN, DN, DN, 2, 3, 4,  1, 0, 0, 0, 0, 0);
    tbl[13] = mk(32'h0020F463, IGEU, 32'h8,        FT_B,    WBN, DN, DN, 0, 1, 2,  1, 1, 0, 0, 1, 0);
    tbl[14] = mk(32'h00000073, IADD, 32'h0,        FT_NONE, WBN, DN, DN, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[15] = mk(32'h0020A463, IADD, 32'h0,        FT_NONE, WBN, DN, DN, 0, 1, 2,  0, 0, 0, 0, 0, 1);
    tbl[16] = mk(32'h00500091, IADD, 32'h0,        FT_NONE, WBN, DN, DN, 0, 0, 5,  0, 0, 0, 0, 0, 1);
    tbl[17] = mk(32'hFE320FA3, IADD, 32'hFFFFFFFF, FT_S,    WBN, DN, DB, 0, 4, 3,  1, 1, 0, 0, 0, 0);
    tbl[18] = mk(32'h022081B3, IADD, 32'h0,        FT_NONE, WBN, DN, DN, 0, 1, 2,  0, 0, 0, 0, 0, 1);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0;
    cur = tbl[0];
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.fmt", 64'(out_fmt), 64'(FT_NONE));
    chk("reset.imm", 64'(out_imm), 64'd0);
    chk("reset.tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle.in_ready", 64'(in_ready), 64'd1);

    // Single addi: visible the cycle after acceptance
    out_ready = 1'b1;
    send(0);
    in_valid = 1'b0;
    chk("addi.out_valid_next_cycle", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    chk("addi.consumed_count", 64'(count), 64'd0);

    // Fill to full with execute stalled, then drain while beq waits
    out_ready = 1'b0;
    send(1);
    send(2);
    in_valid = 1'b0;
    chk("full.count", 64'(count), 64'd2);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(3);
    in_valid = 1'b0;
    drain();

    // Back-to-back stream across tag and pointer wrap
    t0 = cyc;
    for (int i = 0; i < NV; i++) send(i);
    in_valid = 1'b0;
    chk("stream.cycles", 64'(cyc - t0), 64'(NV));
    drain();

    // Flush while full with a new word offered
    out_ready = 1'b0;
    send(6);
    send(7);
    chk("preflush.count", 64'(count), 64'd2);
    cur = tbl[8]; in_ir = tbl[8].ir; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send(9);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    send(10);
    send(11);
    in_valid = 1'b0;
    chk("prereset.count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset.count", 64'(count), 64'd0);
    chk("midreset.out_valid", 64'(out_valid), 64'd0);
    chk("midreset.fmt", 64'(out_fmt), 64'(FT_NONE));
    chk("midreset.imm", 64'(out_imm), 64'd0);
    chk("midreset.tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(12);
    in_valid = 1'b0;
    drain();

    chk("scoreboard.leftover", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_instruction_decoder.md
Name: pipelined_instruction_decoder

Overview:
- Next-generation decode stage for the RV32I/RV64I core.
- Accepts fetched instruction words on a valid/ready handshake and decodes them into the control bundle used by execute: ALU op, immediate, format, write-back type, memory read/write status, register numbers, load_signed, pc_for_input_a and change_branch_instruction.
- Decoded bundles are held in a parametrised FIFO so fetch and execute can stall independently.
- Adds flush, illegal-instruction detection, source-register use flags, XLEN-wide immediates and a per-instruction sequence tag.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extend to XLEN, U-format upper bits sign-extend from IR[31].
DEPTH, 2, FIFO entries of decoded bundles; power of two, >=2.
TAG_W, 4, sequence-tag width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
flush  in  1  drop all buffered entries this cycle.
in_valid  in  1  fetch has an instruction.
in_ready  out  1  decoder accepts this cycle.
in_ir  in  32  instruction word.
in_pc  in  XLEN  instruction address.
out_valid  out  1  head entry valid.
out_ready  in  1  execute consumes head.
out_pc  out  XLEN  pc of head.
out_tag  out  TAG_W  sequence tag of head.
out_alu_op  out  5  ALU op, format.vh IADD..IGEU encodings.
out_imm  out  XLEN  decoded immediate.
out_fmt  out  3  FT_R/I/S/B/U/J/NONE.
out_wb_type  out  2  WB_NORMAL/WB_LOAD/WB_JAL.
out_rd_status  out  2  DM_NONE/BYTE/HWORD/WORD.
out_wr_status  out  2  DM_NONE/BYTE/HWORD/WORD.
out_rd  out  5  destination; 0 for S/B/illegal.
out_rs1, out_rs2  out  5  source registers (IR[19:15], IR[24:20]).
out_use_rs1, out_use_rs2  out  1  source actually read.
out_load_signed, out_pc_a, out_branch  out  1  load_signed, pc_for_input_a, change_branch_instruction.
out_illegal  out  1  undecodable instruction.
count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, immediate):
  - FIFO empty, count=0, out_valid=0, tag counter=0.
  - All out_* bundle fields read the empty-slot value: zeros, with out_fmt=FT_NONE.
- Handshake:
  - in_ready = (count<DEPTH) & !flush.
  - Push when in_valid&in_ready; pop when out_valid&out_ready.
  - in_valid must hold its data until accepted.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 at the earliest. Decode is combinational on in_ir and registered into the FIFO tail.
- FIFO:
  - Head/tail pointers wrap modulo DEPTH.
  - Simultaneous push and pop keeps count unchanged.
  - Full: in_ready=0.
  - Empty: out_valid=0, and out_* hold the last-popped value.
- Flush:
  - Synchronous; at the next edge count=0 and pointers=0.
  - A push in the same cycle is blocked (in_ready=0), and any pop in that cycle is discarded.
  - The tag counter is not reset by flush.
- Tag: each accepted instruction takes the current counter value; the counter then increments, wrapping 2^TAG_W-1 -> 0.
- Decode defaults: ALU IADD, WB_NORMAL, DM_NONE both, load_signed=0, pc_a=0, branch=0, illegal=0.
- Decode by opcode:
  - LUI: FT_U, IPAS.
  - AUIPC: FT_U, pc_a=1.
  - JAL: FT_J, pc_a=1, branch=1, WB_JAL.
  - JALR: FT_I, branch=1, WB_JAL, use_rs1.
  - BR: FT_B, ops per funct3 (IEQ/INE/ILT/IGE/ILTU/IGEU); funct3 010/011 illegal.
  - LOAD: FT_I, WB_LOAD.
    - funct3 000/001/010 signed (B/H/W).
    - funct3 100/101/110 unsigned (B/H/W).
    - funct3 011/111 illegal.
  - STORE: FT_S, sb/sh/sw; other funct3 illegal.
  - OP-IMM: FT_I.
    - slli requires funct7=0.
    - srli/srai require funct7 0000000/0100000; otherwise illegal.
  - OP: FT_R; funct7 other than 0000000 (or 0100000 for sub/sra) is illegal.
  - FENCE, SYSTEM: FT_NONE, decoded as NOP (not illegal).
  - Any other opcode, or IR[1:0]!=11: illegal.
- Illegal bundle: FT_NONE, IADD, rd=0, use_rs1/rs2=0, no memory access, branch=0, out_illegal=1.
- Source-use flags:
  - use_rs1 = fmt in {R,I,S,B}, except LUI/AUIPC/JAL/FENCE/SYSTEM.
  - use_rs2 = fmt in {R,S,B}.
- Immediate formats:
  - I: IR[31:20].
  - S: {IR[31:25],IR[11:7]}.
  - B: {IR[31],IR[7],IR[30:25],IR[11:8],0}.
  - U: {IR[31:12],12'h0}.
  - J: {IR[31],IR[19:12],IR[20],IR[30:21],0}.
  - All formats sign-extend from IR[31] to XLEN; R and FT_NONE give 0.

Test Plan:
- Reset mid-stream with 2 entries buffered -> outputs clear immediately, count=0, out_valid=0; next accepted instruction carries tag 0.
- Push 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, IADD, FT_I, imm=5, rd=1, use_rs1=1, use_rs2=0, tag=0.
- Push 0x12345137 (lui), 0x00112423 (sw x1,8(x2)), 0xFE000EE3 (beq -4) with out_ready=0, DEPTH=2:
  - in_ready drops after 2 pushes.
  - Draining yields lui: IPAS, imm=0x12345000, rd=2; then sw: DM_WORD write, imm=8, rd=0, use_rs2=1.
  - After draining, beq is accepted: IEQ, branch=1, imm=0xFFFFFFFC, or 0xFFFF_FFFF_FFFF_FFFC at XLEN=64.
- Illegal words 0x0000707F (bad opcode) and 0x40001013 (slli with funct7!=0) -> out_illegal=1, rd=0, no memory access.
- FIFO full plus flush asserted with in_valid high -> next cycle count=0, out_valid=0, input not accepted; tags continue from the pre-flush value.
- Push 2^TAG_W+1 instructions back-to-back with out_ready=1 -> one per cycle throughput; tag wraps 15 -> 0 (TAG_W=4); head/tail wrap preserves order.
